// File: rtl/display_share_scheduler.sv
// display_share_scheduler
//   Time-shares a 4-digit multiplexed 7-segment display between two
//   requesters (A and B). Arbitration is round-robin with a minimum hold of
//   HOLD_FRAMES frames. Digits are scanned from an internal prescaler, which
//   runs as a clock enable on the single system clock. Ownership changes only
//   at frame boundaries.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_a      requester A wants the display
//   val_a      A value; nibble k is shown on digit k
//   req_b      requester B wants the display
//   val_b      B value; nibble k is shown on digit k
//   grant_a    A currently owns the display
//   grant_b    B currently owns the display
//   digit_bcd  nibble for the active digit, sent to the BCD decoder
//   on_off     digit enables, active-low, at most one digit low at a time
//   frame_end  1-cycle pulse in the last cycle of each frame
module display_share_scheduler #(
    parameter int unsigned SCAN_DIV    = 208333,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] val_a,
    input  logic        req_b,
    input  logic [15:0] val_b,
    output logic        grant_a,
    output logic        grant_b,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  on_off,
    output logic        frame_end
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

    state_e         state_q;
    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  presc_d;
    logic [1:0]     digit_q;
    logic [HW-1:0]  hold_q;
    logic [HW-1:0]  hold_d;
    logic           last_b_q;   // 1: B was served last (reset value, so A wins the first tie)
    logic [15:0]    disp_q;

    logic           tick;
    logic           hold_done;
    logic           go_a;
    logic           go_b;
    logic           go_idle;

    assign tick      = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (digit_q == 2'd3);
    assign presc_d   = tick ? '0 : presc_q + PW'(1);

    // Saturating frame count for the current owner; hold_done means the
    // minimum hold has elapsed once this frame_end is accounted for.
    assign hold_d    = (hold_q >= HW'(HOLD_FRAMES)) ? HW'(HOLD_FRAMES) : hold_q + HW'(1);
    assign hold_done = (hold_d >= HW'(HOLD_FRAMES));

    // Transition decisions. They are evaluated only on frame_end, so the
    // display never changes owner mid-frame.
    always_comb begin
        go_a    = 1'b0;
        go_b    = 1'b0;
        go_idle = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (req_a && req_b) begin
                        go_a = last_b_q;
                        go_b = !last_b_q;
                    end else begin
                        go_a = req_a;
                        go_b = req_b;
                    end
                end
                SERVE_A: begin
                    if (hold_done) begin
                        if (req_b)       go_b    = 1'b1;
                        else if (!req_a) go_idle = 1'b1;
                    end
                end
                SERVE_B: begin
                    if (hold_done) begin
                        if (req_a)       go_a    = 1'b1;
                        else if (!req_b) go_idle = 1'b1;
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            digit_q  <= '0;
            hold_q   <= '0;
            last_b_q <= 1'b1;
            disp_q   <= '0;
        end else begin
            presc_q <= presc_d;
            if (tick) digit_q <= digit_q + 2'd1;

            // Live update while the owner keeps requesting. Otherwise the
            // last value stays latched.
            if (state_q == SERVE_A && req_a) disp_q <= val_a;
            if (state_q == SERVE_B && req_b) disp_q <= val_b;

            if (frame_end && state_q != IDLE) hold_q <= hold_d;

            // Entry actions come last so that they override the updates above.
            if (go_a) begin
                state_q  <= SERVE_A;
                hold_q   <= '0;
                last_b_q <= 1'b0;
                disp_q   <= val_a;
            end else if (go_b) begin
                state_q  <= SERVE_B;
                hold_q   <= '0;
                last_b_q <= 1'b1;
                disp_q   <= val_b;
            end else if (go_idle) begin
                state_q  <= IDLE;
            end
        end
    end

    always_comb begin
        grant_a   = (state_q == SERVE_A);
        grant_b   = (state_q == SERVE_B);
        on_off    = 4'b1111;
        digit_bcd = '0;
        if (state_q == SERVE_A || state_q == SERVE_B) begin
            on_off    = ~(4'b0001 << digit_q);
            digit_bcd = disp_q[{digit_q, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_display_share_scheduler.sv
// Testbench for display_share_scheduler with SCAN_DIV=4 and HOLD_FRAMES=2.
// A frame is 16 cycles. Cycle 0 is the first cycle after reset is released.
module tb_display_share_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [15:0] val_a, val_b;
    logic        grant_a, grant_b, frame_end;
    logic [3:0]  digit_bcd, on_off;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [10:0] sbq[$];
    logic [10:0] got, expv;

    display_share_scheduler #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .val_a(val_a),
        .req_b(req_b), .val_b(val_b),
        .grant_a(grant_a), .grant_b(grant_b),
        .digit_bcd(digit_bcd), .on_off(on_off),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    // Expected {grant_a, grant_b, on_off, digit_bcd, frame_end} in cycle c.
    // srv: 0 = idle, 1 = A owns, 2 = B owns. v is the value being shown.
    function automatic logic [10:0] exp_vec(input int srv, input int c, input logic [15:0] v);
        int d;
        logic [3:0] oo, bcd;
        d   = (c / 4) % 4;
        oo  = 4'b1111;
        bcd = 4'd0;
        if (srv != 0) begin
            oo     = 4'b1111;
            oo[d]  = 1'b0;
            bcd    = v[4*d +: 4];
        end
        return {srv == 1, srv == 2, oo, bcd, (c % 16) == 15};
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset is held for one edge while the requests are high, so reset has
    // to dominate them.
    task automatic do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        cyc   = 0;
        sbq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 64; c++) begin
            sbq.push_back(exp_vec(0, cyc, 16'h0));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    task automatic test_grant_scan();
        do_reset();
        req_a = 1'b1;
        val_a = 16'h4321;
        for (int c = 0; c < 48; c++) begin
            sbq.push_back(exp_vec(cyc >= 16 ? 1 : 0, cyc, 16'h4321));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL grant_scan c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    task automatic test_round_robin();
        int srv;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        val_a = 16'h4321;
        val_b = 16'hBEEF;
        for (int c = 0; c < 96; c++) begin
            srv = (cyc < 16) ? 0 : (cyc < 48) ? 1 : (cyc < 80) ? 2 : 1;
            sbq.push_back(exp_vec(srv, cyc, srv == 2 ? 16'hBEEF : 16'h4321));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL round_robin c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    task automatic test_drop_hold();
        do_reset();
        req_a = 1'b1;
        val_a = 16'h4321;
        for (int c = 0; c < 64; c++) begin
            if (cyc == 32) begin
                req_a = 1'b0;
                val_a = 16'h9999;
            end
            sbq.push_back(exp_vec((cyc >= 16 && cyc < 48) ? 1 : 0, cyc, 16'h4321));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL drop_hold c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    task automatic test_live_update();
        do_reset();
        req_a = 1'b1;
        val_a = 16'h0001;
        for (int c = 0; c < 48; c++) begin
            if (cyc == 22) val_a = 16'h0002;
            sbq.push_back(exp_vec(cyc >= 16 ? 1 : 0, cyc, cyc >= 23 ? 16'h0002 : 16'h0001));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL live_update c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    // Reset at cycle 40 while B owns the display (40 is mid-frame, so the
    // frame_end timing afterwards shows whether the scan counters restarted).
    task automatic test_reset_mid_serve_b();
        do_reset();
        req_b = 1'b1;
        val_a = 16'h4321;
        val_b = 16'hBEEF;
        for (int c = 0; c <= 40; c++) begin
            sbq.push_back(exp_vec(cyc >= 16 ? 2 : 0, cyc, 16'hBEEF));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_mid_b_pre c=%0d got=%b exp=%b", cyc, got, expv);
            end
            if (c == 40) begin
                reset = 1'b1;
                req_a = 1'b1;
            end
            tick_clk();
        end
        reset = 1'b0;
        cyc   = 0;
        for (int c = 0; c < 32; c++) begin
            sbq.push_back(exp_vec(cyc >= 16 ? 1 : 0, cyc, 16'h4321));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_mid_b_post c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    // Reset while A owns the display. A tie after reset must still go to A,
    // because reset makes B the last-served requester.
    task automatic test_reset_last_a();
        do_reset();
        req_a = 1'b1;
        val_a = 16'h1357;
        val_b = 16'hBEEF;
        for (int c = 0; c <= 24; c++) begin
            sbq.push_back(exp_vec(cyc >= 16 ? 1 : 0, cyc, 16'h1357));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_last_pre c=%0d got=%b exp=%b", cyc, got, expv);
            end
            if (c == 24) begin
                reset = 1'b1;
                req_b = 1'b1;
            end
            tick_clk();
        end
        reset = 1'b0;
        cyc   = 0;
        for (int c = 0; c < 32; c++) begin
            sbq.push_back(exp_vec(cyc >= 16 ? 1 : 0, cyc, 16'h1357));
            got  = {grant_a, grant_b, on_off, digit_bcd, frame_end};
            expv = sbq.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_last_post c=%0d got=%b exp=%b", cyc, got, expv);
            end
            tick_clk();
        end
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        val_a = 16'h0;
        val_b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_grant_scan();
        test_round_robin();
        test_drop_hold();
        test_live_update();
        test_reset_mid_serve_b();
        test_reset_last_a();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
